// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the program counter sequencer: FSM state encoding,
// next-PC selector codes and the default reset/interrupt vectors.
package pc_sequencer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_IRQ_VECTOR   = 32'h0000_0040;

endpackage

// File: rtl/pc_next_calc.sv
// Purely combinational next-address selection for the program counter.
// All arithmetic wraps modulo 2^ADDR_W; eret overrides the pc_sel choice.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] epc,
  input  logic [1:0]        pc_sel,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              eret,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc = pc + ADDR_W'(1);

  // Select the address of the instruction that follows the one retiring now
  always_comb begin
    next_pc = seq_pc;
    if (eret) begin
      next_pc = epc;
    end else begin
      case (pc_sel)
        PC_SEQ:    next_pc = seq_pc;
        PC_BRANCH: next_pc = branch_taken ? (seq_pc + branch_offset) : seq_pc;
        PC_JUMP:   next_pc = jump_target;
        PC_REG:    next_pc = reg_target;
        default:   next_pc = seq_pc;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch/execute FSM with an instruction memory
// handshake, halt/resume and single-level interrupt entry and return.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(DEFAULT_IRQ_VECTOR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic [1:0]        pc_sel,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              eret,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic              halted
);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              in_isr;
  logic              retire;
  logic              isr_after_eret;
  logic              take_irq;
  logic [ADDR_W-1:0] next_pc;

  pc_next_calc #(
    .ADDR_W(ADDR_W)
  ) u_next (
    .pc           (pc),
    .epc          (epc),
    .pc_sel       (pc_sel),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump_target  (jump_target),
    .reg_target   (reg_target),
    .eret         (eret),
    .next_pc      (next_pc)
  );

  // Outputs derived straight from state so imem_req drops with an async reset
  assign imem_req  = (state == ST_FETCH);
  assign halted    = (state == ST_HALTED);
  assign imem_addr = pc;

  // An eret in the same cycle re-opens the interrupt window; halt wins over irq
  assign retire         = (state == ST_EXEC) && exec_done;
  assign isr_after_eret = in_isr && !eret;
  assign take_irq       = irq && !isr_after_eret && !halt_req;

  // Next-state selection; each input is only honoured in its own state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start)     state_next = ST_FETCH;
      ST_FETCH:  if (imem_ack)  state_next = ST_EXEC;
      ST_EXEC:   if (exec_done) state_next = halt_req ? ST_HALTED : ST_FETCH;
      ST_HALTED: if (resume)    state_next = ST_FETCH;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // State, PC, EPC and ISR-flag registers; PC only changes when an instruction retires
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_VECTOR;
      epc         <= '0;
      in_isr      <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      instr_valid <= (state == ST_FETCH) && imem_ack;
      if (retire) begin
        if (take_irq) begin
          epc    <= next_pc;
          pc     <= IRQ_VECTOR;
          in_isr <= 1'b1;
        end else begin
          pc     <= next_pc;
          in_isr <= isr_after_eret;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized instruction stream compared against a transaction-level model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int          ADDR_W  = 32;
  localparam logic [31:0] IRQ_VEC = 32'h0000_0040;

  logic        clock;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        exec_done;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] jump_target;
  logic [31:0] reg_target;
  logic        eret;
  logic        halt_req;
  logic        resume;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        halted;

  logic [31:0] modelPc;
  logic [31:0] modelEpc;
  bit          modelInIsr;
  bit          modelHalted;

  int checkCount;
  int passCount;
  int cycleCount;

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(32'h0000_0000),
    .IRQ_VECTOR  (IRQ_VEC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .pc_sel       (pc_sel),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump_target  (jump_target),
    .reg_target   (reg_target),
    .eret         (eret),
    .halt_req     (halt_req),
    .resume       (resume),
    .irq          (irq),
    .pc           (pc),
    .epc          (epc),
    .halted       (halted)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used to measure instruction throughput
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Architectural state after a retirement, compared with the model
  task automatic checkArch(input string tag);
    checkOutput({tag, "_pc"}, pc, modelPc);
    checkOutput({tag, "_epc"}, epc, modelEpc);
    checkOutput({tag, "_halted"}, {31'd0, halted}, {31'd0, modelHalted});
    checkOutput({tag, "_req"}, {31'd0, imem_req}, {31'd0, !modelHalted});
  endtask

  task automatic clearInputs();
    start = 0; imem_ack = 0; exec_done = 0; pc_sel = 2'b00; branch_taken = 0;
    branch_offset = '0; jump_target = '0; reg_target = '0;
    eret = 0; halt_req = 0; resume = 0; irq = 0;
  endtask

  // Model of one retirement, written from the architectural rules
  task automatic modelRetire(input logic [1:0] sel, input bit taken, input logic [31:0] off,
                             input logic [31:0] jt, input logic [31:0] rt,
                             input bit er, input bit hr, input bit iq);
    logic [31:0] following;
    following = modelPc + 32'd1;
    if (er)                 following = modelEpc;
    else if (sel == 2'b01)  following = taken ? modelPc + 32'd1 + off : modelPc + 32'd1;
    else if (sel == 2'b10)  following = jt;
    else if (sel == 2'b11)  following = rt;
    if (er) modelInIsr = 0;
    if (hr) begin
      modelPc     = following;
      modelHalted = 1;
    end else if (iq && !modelInIsr) begin
      modelEpc   = following;
      modelPc    = IRQ_VEC;
      modelInIsr = 1;
    end else begin
      modelPc = following;
    end
  endtask

  // One full instruction from FETCH: ack after ackDelay wait cycles, exec_done after execDelay
  task automatic applyStimulus(input int ackDelay, input int execDelay,
                               input logic [1:0] sel, input bit taken, input logic [31:0] off,
                               input logic [31:0] jt, input logic [31:0] rt,
                               input bit er, input bit hr, input bit iq);
    for (int k = 0; k < ackDelay; k++) begin
      checkOutput("wait_req", {31'd0, imem_req}, 32'd1);
      checkOutput("wait_addr", imem_addr, modelPc);
      checkOutput("wait_iv", {31'd0, instr_valid}, 32'd0);
      exec_done = 1'($urandom_range(0, 1));
      halt_req  = 1'($urandom_range(0, 1));
      resume    = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    clearInputs();
    checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
    checkOutput("fetch_addr", imem_addr, modelPc);
    imem_ack = 1;
    @(negedge clock);
    imem_ack = 0;
    checkOutput("instr_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("exec_req", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < execDelay; k++) begin
      imem_ack = 1'($urandom_range(0, 1));
      start    = 1'($urandom_range(0, 1));
      @(negedge clock);
      checkOutput("exec_iv_low", {31'd0, instr_valid}, 32'd0);
      checkOutput("exec_pc", pc, modelPc);
    end
    clearInputs();
    pc_sel = sel; branch_taken = taken; branch_offset = off;
    jump_target = jt; reg_target = rt; eret = er; halt_req = hr; irq = iq;
    exec_done = 1;
    @(negedge clock);
    clearInputs();
    modelRetire(sel, taken, off, jt, rt, er, hr, iq);
  endtask

  // Sit in HALTED for a while (irq must not wake it), then resume
  task automatic doResume(input int waitCycles);
    for (int k = 0; k < waitCycles; k++) begin
      irq = 1; start = 1; exec_done = 1;
      @(negedge clock);
      checkOutput("halt_hold", {31'd0, halted}, 32'd1);
      checkOutput("halt_pc", pc, modelPc);
      checkOutput("halt_req_low", {31'd0, imem_req}, 32'd0);
    end
    clearInputs();
    resume = 1;
    @(negedge clock);
    resume = 0;
    modelHalted = 0;
    checkOutput("resume_halted", {31'd0, halted}, 32'd0);
    checkOutput("resume_req", {31'd0, imem_req}, 32'd1);
    checkOutput("resume_addr", imem_addr, modelPc);
  endtask

  task automatic modelReset();
    modelPc = 32'd0; modelEpc = 32'd0; modelInIsr = 0; modelHalted = 0;
  endtask

  initial begin
    int c0;
    logic [1:0] rSel;
    bit rEr, rHr, rIq;
    checkCount = 0; passCount = 0; cycleCount = 0;
    clearInputs();
    modelReset();
    reset = 0;
    repeat (3) @(negedge clock);
    reset = 1;

    // Reset state and idle behaviour; resume is ignored in IDLE
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_epc", epc, 32'd0);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_iv", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    resume = 1; imem_ack = 1; exec_done = 1;
    @(negedge clock);
    clearInputs();
    checkOutput("idle_stay", {31'd0, imem_req}, 32'd0);
    start = 1;
    @(negedge clock);
    start = 0;
    checkOutput("start_req", {31'd0, imem_req}, 32'd1);

    // Three sequential zero-wait instructions: addresses 0,1,2, two cycles each
    c0 = cycleCount;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cpi_2", 32'(cycleCount - c0), 32'd6);
    checkArch("seq3");
    checkOutput("seq3_pc3", pc, 32'd3);

    // Branches and wrap-around
    applyStimulus(0, 0, 2'b10, 0, 0, 32'd10, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'b01, 1, 32'hFFFF_FFFB, 0, 0, 0, 0, 0);
    checkArch("br_taken");
    checkOutput("br_taken_6", pc, 32'd6);
    applyStimulus(0, 0, 2'b11, 0, 0, 0, 32'd10, 0, 0, 0);
    applyStimulus(0, 2, 2'b01, 0, 32'hFFFF_FFFB, 0, 0, 0, 0, 0);
    checkOutput("br_not_taken_11", pc, 32'd11);
    applyStimulus(0, 0, 2'b10, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_0", pc, 32'd0);

    // Interrupt entry, nested irq ignored, eret, then a fresh irq is taken
    applyStimulus(0, 0, 2'b10, 0, 0, 32'd20, 0, 0, 0, 0);
    applyStimulus(0, 0, 2'b10, 0, 0, 32'd100, 0, 0, 0, 1);
    checkArch("irq_entry");
    checkOutput("irq_epc_100", epc, 32'd100);
    checkOutput("irq_pc_40", pc, 32'h40);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("irq_nested_ign", pc, 32'h41);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("eret_pc_100", pc, 32'd100);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    checkArch("irq_again");
    checkOutput("irq_again_epc", epc, 32'd101);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
    checkArch("eret_irq_same");
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    checkArch("eret_back");

    // Halt beats irq; epc unchanged; resume fetches the next address
    applyStimulus(0, 0, 2'b10, 0, 0, 32'd7, 0, 0, 0, 0);
    c0 = int'(epc);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1);
    checkArch("halt");
    checkOutput("halt_pc_8", pc, 32'd8);
    checkOutput("halt_epc_same", epc, 32'(c0));
    doResume(3);
    checkOutput("resume_addr_8", imem_addr, 32'd8);

    // Slow memory: request held for four cycles with a stable address
    applyStimulus(3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkArch("slow_mem");

    // Randomized instruction stream against the model
    for (int i = 0; i < 300; i++) begin
      rSel = 2'($urandom_range(0, 3));
      rEr  = modelInIsr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rHr  = ($urandom_range(0, 14) == 0);
      rIq  = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 2), rSel, 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, rEr, rHr, rIq);
      checkArch("rand");
      if (modelHalted) doResume($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a fetch
    applyStimulus(0, 0, 2'b10, 0, 0, 32'd55, 0, 0, 0, 0);
    checkOutput("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2 reset = 0;
    #1;
    modelReset();
    checkOutput("async_rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("async_rst_pc", pc, 32'd0);
    checkOutput("async_rst_epc", epc, 32'd0);
    checkOutput("async_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    checkOutput("post_rst_idle", {31'd0, imem_req}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns and sequences the processor's program counter: fetch handshake with instruction memory, next-address selection, halt/resume and single-level interrupt entry/return.
- Sits between the instruction memory port and the datapath/control unit; replaces free-running PC update with an explicit fetch/execute FSM.
- Word-addressed; all PC arithmetic is modulo 2^ADDR_W.

Parameters:
- ADDR_W, 32, width of PC, EPC and all address/target ports
- RESET_VECTOR, 0, PC value loaded on reset
- IRQ_VECTOR, 32'h0000_0040, PC loaded on interrupt entry

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching
- imem_req  out  1  instruction fetch request, held until imem_ack
- imem_addr  out  ADDR_W  fetch address (always equals pc)
- imem_ack  in  1  memory accepted/returned instruction this cycle
- instr_valid  out  1  one-cycle pulse: fetched instruction ready for decode
- exec_done  in  1  datapath finished current instruction; next-PC inputs valid this cycle
- pc_sel  in  2  00 sequential, 01 conditional branch, 10 absolute jump, 11 register jump
- branch_taken  in  1  condition result for pc_sel=01
- branch_offset  in  ADDR_W  signed word offset for branch
- jump_target  in  ADDR_W  absolute target for pc_sel=10
- reg_target  in  ADDR_W  register value for pc_sel=11
- eret  in  1  return from interrupt (sampled with exec_done)
- halt_req  in  1  halt after current instruction (sampled with exec_done)
- resume  in  1  leave HALTED
- irq  in  1  level interrupt request
- pc  out  ADDR_W  current program counter
- epc  out  ADDR_W  saved return address
- halted  out  1  high while in HALTED

Behaviour:
- Reset (async, reset=0): state=IDLE, pc=RESET_VECTOR, epc=0, in_isr=0; imem_req, instr_valid, halted=0.
- States: IDLE, FETCH, EXEC, HALTED. imem_req=1 exactly in FETCH; halted=1 exactly in HALTED.
- IDLE: start=1 -> FETCH next cycle.
- FETCH: wait for imem_ack; on ack -> EXEC; instr_valid pulses for the first EXEC cycle only. Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles/instruction minimum.
- EXEC: wait for exec_done; exec_done before instr_valid is impossible (instr_valid is in EXEC cycle 1, exec_done accepted from that same cycle).
- Next PC on exec_done, computed combinationally as seq = pc+1:
  - eret=1: next = epc, in_isr cleared (overrides pc_sel).
  - else pc_sel 00 -> seq; 01 -> branch_taken ? seq+branch_offset : seq; 10 -> jump_target; 11 -> reg_target.
  - All sums wrap modulo 2^ADDR_W (pc=all-ones, seq -> 0).
- Priority on exec_done cycle: halt_req > irq > normal.
  - halt_req: pc<=next, -> HALTED.
  - else irq=1 and in_isr=0 (in_isr after any eret clear): epc<=next, pc<=IRQ_VECTOR, in_isr<=1, -> FETCH.
  - else pc<=next, -> FETCH.
- irq while in_isr=1 is ignored (not latched); still asserted after eret -> taken on the next exec_done.
- HALTED: pc frozen; resume=1 -> FETCH next cycle. irq does not wake HALTED.
- start ignored outside IDLE; resume ignored outside HALTED; exec_done ignored outside EXEC; imem_ack ignored outside FETCH.
- Reset mid-fetch or mid-exec: immediate return to reset state; imem_req drops asynchronously.

Decomposition:
- Shared package: state encoding constants (ST_IDLE..ST_HALTED), pc_sel codes (PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG), default vectors.
- One natural sub-module: pc_next_calc (pure combinational next-address mux/adder); FSM and registers stay in pc_sequencer.

Test Plan:
- Reset, start, imem_ack on first FETCH cycle, pc_sel=00 x3 -> imem_addr 0,1,2; instr_valid one pulse per instruction; 2 cycles each.
- pc=10, pc_sel=01, taken, offset=-5 -> pc=6; not taken -> pc=11; pc=all-ones sequential -> pc=0.
- pc=20, exec_done with irq=1, pc_sel=10 target 100 -> epc=100, pc=0x40; second irq during ISR ignored; eret -> pc=100, next irq taken.
- exec_done with halt_req=1 and irq=1 at pc=7 -> halted=1, pc=8, epc unchanged; resume -> FETCH at 8.
- imem_ack delayed 3 cycles -> imem_req held 4 cycles, pc stable; reset pulled low mid-FETCH -> pc=RESET_VECTOR, imem_req=0 without clock edge.
